// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared definitions for the instruction-memory boot loader: loader FSM state
//   encoding, the default frame start byte and the number of bytes per word.
//   No ports; imported by imem_boot_loader and byte_word_packer.
package imem_loader_pkg;

  // Raw encodings kept as plain constants so older code that compares
  // against numeric state values keeps working.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_LO = 3'd1;
  localparam logic [2:0] ST_LEN_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERR    = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LEN_LO = ST_LEN_LO,
    LEN_HI = ST_LEN_HI,
    DATA   = ST_DATA,
    CHECK  = ST_CHECK,
    DONE   = ST_DONE,
    ERR    = ST_ERR
  } state_e;

  localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;
  localparam int         WORD_BYTES    = 4;

endpackage

// File: rtl/imem_boot_loader_byte_word_packer.sv
// byte_word_packer
//   Assembles a little-endian 32-bit word from a stream of bytes. The first
//   byte after a clear lands in bits [7:0], the fourth in bits [31:24].
//   Ports:
//     clk, reset  : clock and synchronous active-high reset
//     clear       : restart packing at byte 0 (takes priority over byte_valid)
//     byte_valid  : byte_in is accepted this cycle
//     byte_in     : incoming byte
//     word_valid  : combinational, high while the 4th byte of a word is accepted
//     word_out    : combinational, the word including the byte being accepted
module byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word_out
);

  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] word_q, word_d;
  logic [31:0] word_next;

  // Each lane takes the incoming byte only when the index points at it;
  // the full word is therefore already complete while the last byte arrives,
  // letting the parent register the write one cycle later.
  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      assign word_next[8*gi +: 8] = (byte_valid && (byte_idx_q == 2'(gi)))
                                    ? byte_in : word_q[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    if (clear) begin
      byte_idx_d = 2'd0;
      word_d     = 32'd0;
    end else if (byte_valid) begin
      byte_idx_d = byte_idx_q + 2'd1;  // wraps 3 -> 0 at the word boundary
      word_d     = word_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx_q <= 2'd0;
      word_q     <= 32'd0;
    end else begin
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
    end
  end

  assign word_valid = byte_valid && (byte_idx_q == 2'd3);
  assign word_out   = word_next;

endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Receives a framed byte stream (MAGIC, LEN_LO, LEN_HI, 4*N payload bytes,
//   XOR checksum), writes the payload as little-endian words into instruction
//   memory at BASE_ADDR + 4*k, and keeps the CPU in reset until a complete
//   image with a matching checksum has been loaded.
//   Ports:
//     clk, reset    : clock and synchronous active-high reset
//     rx_data/valid : incoming byte stream, at most one byte per cycle
//     imem_we       : one-cycle write strobe per word
//     imem_addr     : byte address of the current write
//     imem_wdata    : word being written
//     cpu_reset     : held high except while a verified image is present
//     done          : verified image present
//     error         : frame error, sticky until reset
//     words_loaded  : words written in the current frame
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned BASE_ADDR   = 0,
  parameter logic [7:0]  MAGIC       = DEFAULT_MAGIC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [16:0]       DEPTH_LIM = 17'(DEPTH_WORDS);

  state_e              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [7:0]          chk_q, chk_d;
  logic [15:0]         words_loaded_q, words_loaded_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;

  logic                enter_len;
  logic [15:0]         len_full;
  logic [15:0]         words_inc;
  logic                pack_valid;
  logic                word_valid;
  logic [31:0]         word_out;

  assign pack_valid = rx_valid && (state_q == DATA);

  byte_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (enter_len),
    .byte_valid (pack_valid),
    .byte_in    (rx_data),
    .word_valid (word_valid),
    .word_out   (word_out)
  );

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    chk_d          = chk_q;
    words_loaded_d = words_loaded_q;
    imem_we_d      = 1'b0;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    enter_len      = 1'b0;
    len_full       = {rx_data, len_q[7:0]};
    words_inc      = words_loaded_q + 16'd1;

    if (rx_valid) begin
      case (state_q)
        IDLE: begin
          if (rx_data == MAGIC) enter_len = 1'b1;
        end
        LEN_LO: begin
          len_d   = {len_q[15:8], rx_data};
          state_d = LEN_HI;
        end
        LEN_HI: begin
          len_d = len_full;
          if (len_full == 16'd0)                 state_d = CHECK;
          else if ({1'b0, len_full} > DEPTH_LIM) state_d = ERR;
          else                                   state_d = DATA;
        end
        DATA: begin
          chk_d = chk_q ^ rx_data;
          if (word_valid) begin
            imem_we_d      = 1'b1;
            imem_wdata_d   = word_out;
            // Word k goes to BASE + 4*k; words_loaded_q is k here.
            imem_addr_d    = BASE + (ADDR_W'(words_loaded_q) << 2);
            words_loaded_d = words_inc;
            if (words_inc == len_q) state_d = CHECK;
          end
        end
        CHECK: begin
          state_d = (rx_data == chk_q) ? DONE : ERR;
        end
        DONE: begin
          if (rx_data == MAGIC) enter_len = 1'b1;
        end
        ERR: begin
          state_d = ERR;
        end
        default: state_d = IDLE;
      endcase
    end

    // Starting a frame (first load or re-load) wipes all per-frame state.
    if (enter_len) begin
      state_d        = LEN_LO;
      chk_d          = 8'd0;
      words_loaded_d = 16'd0;
      imem_addr_d    = BASE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      len_q          <= 16'd0;
      chk_q          <= 8'd0;
      words_loaded_q <= 16'd0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= BASE;
      imem_wdata_q   <= 32'd0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      chk_q          <= chk_d;
      words_loaded_q <= words_loaded_d;
      imem_we_q      <= imem_we_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
    end
  end

  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign words_loaded = words_loaded_q;
  assign done         = (state_q == DONE);
  assign error        = (state_q == ERR);
  assign cpu_reset    = (state_q != DONE);

endmodule
